// File: rtl/vending_pkg.sv
// Shared types and constant tables for the vending controller.
// Product prices and the hex-to-7-segment decode live here.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SELECTED,
        DISPENSE,
        REFUND
    } state_t;

    localparam int MAX_PROD = 8;

    // Entry i is the price of product i
    localparam logic [MAX_PROD-1:0][3:0] COST = {
        4'd8, 4'd9, 4'd2, 4'd6,
        4'd4, 4'd7, 4'd5, 4'd3
    };

    // Active-low segments {g,f,e,d,c,b,a}, entry i shows hex digit i
    localparam logic [15:0][6:0] SEG7 = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [3:0] cost_of(input logic [2:0] idx);
        return COST[idx];
    endfunction

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        return SEG7[v];
    endfunction

endpackage

// File: rtl/vending_controller_btn_sync_edge.sv
// Multi-stage synchroniser plus falling-edge detect for active-low pins.
// Reset forces every stage to the released (high) level.
module btn_sync_edge #(
    parameter int W           = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pin_n,
    output logic [W-1:0] fall
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]                  prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_n};
        prev_d = sync_q[SYNC_STAGES-1];
        fall   = prev_q & ~sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Vending controller: selection lock, coin credit, dispense/change, refund.
// All outputs come straight from flops.
module vending_controller
    import vending_pkg::*;
#(
    parameter int N_PROD      = 4,
    parameter int CREDIT_W    = 4,
    parameter int TIMEOUT     = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PROD-1:0]   btn,
    input  logic                cancel_n,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    output logic [N_PROD-1:0]   led,
    output logic [6:0]          display,
    output logic                dispense,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_value,
    output logic                coin_reject
);

    localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int SUM_W = ((CREDIT_W > 4) ? CREDIT_W : 4) + 1;

    localparam logic [SUM_W-1:0] MAX_CREDIT = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

    logic [N_PROD:0] fall;

    btn_sync_edge #(
        .W          (N_PROD + 1),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .pin_n({cancel_n, btn}),
        .fall (fall)
    );

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [N_PROD-1:0]     led_q, led_d;
    logic [6:0]            disp_q, disp_d;
    logic                  dispense_q, dispense_d;
    logic                  chg_v_q, chg_v_d;
    logic [CREDIT_W-1:0]   chg_q, chg_d;
    logic                  reject_q, reject_d;

    logic                  btn_hit;
    logic                  cancel_hit;
    logic [IDX_W-1:0]      btn_idx;
    logic [IDX_W-1:0]      idx_sel;
    logic                  coin_ok;
    logic [SUM_W-1:0]      base;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      avail;
    logic [SUM_W-1:0]      cost_now;
    logic [SUM_W-1:0]      owed;

    // Lowest-index button wins when several edges land together
    always_comb begin
        btn_hit = |fall[N_PROD-1:0];
        btn_idx = '0;
        for (int i = N_PROD - 1; i >= 0; i--) begin
            if (fall[i]) btn_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        led_d      = led_q;
        tmo_d      = '0;
        dispense_d = 1'b0;
        chg_v_d    = 1'b0;
        chg_d      = '0;
        cancel_hit = fall[N_PROD];

        // Credit is being paid out this cycle, so a new coin starts from zero
        base     = (state_q == DISPENSE || state_q == REFUND)
                 ? '0 : SUM_W'(credit_q);
        sum      = base + SUM_W'(coin_value);
        coin_ok  = coin_valid && (sum <= MAX_CREDIT);
        reject_d = coin_valid && !coin_ok;
        avail    = coin_ok ? sum : base;
        credit_d = CREDIT_W'(avail);

        idx_sel  = (state_q == IDLE) ? btn_idx : sel_q;
        cost_now = SUM_W'(cost_of(3'(idx_sel)));

        unique case (state_q)
            IDLE: begin
                if (btn_hit) begin
                    sel_d   = btn_idx;
                    led_d   = ~(N_PROD'(1) << btn_idx);
                    state_d = (avail >= cost_now) ? DISPENSE : SELECTED;
                end else if (cancel_hit && avail != '0) begin
                    state_d = REFUND;
                end
            end
            SELECTED: begin
                if (avail >= cost_now) begin
                    state_d = DISPENSE;
                end else if (cancel_hit
                             || (!coin_valid && tmo_q == TMO_LAST)) begin
                    state_d = REFUND;
                end else if (!coin_valid) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                led_d   = '1;
                state_d = IDLE;
            end
        endcase

        if (state_d == DISPENSE) begin
            dispense_d = 1'b1;
            chg_v_d    = avail > cost_now;
            chg_d      = chg_v_d ? CREDIT_W'(avail - cost_now) : '0;
        end else if (state_d == REFUND) begin
            chg_v_d = 1'b1;
            chg_d   = credit_d;
        end

        owed = cost_now - avail;
        if (state_d == SELECTED) begin
            disp_d = hex_seg(4'(owed));
        end else begin
            disp_d = hex_seg(4'(credit_d));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            sel_q      <= '0;
            tmo_q      <= '0;
            led_q      <= '1;
            disp_q     <= SEG7[0];
            dispense_q <= 1'b0;
            chg_v_q    <= 1'b0;
            chg_q      <= '0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            sel_q      <= sel_d;
            tmo_q      <= tmo_d;
            led_q      <= led_d;
            disp_q     <= disp_d;
            dispense_q <= dispense_d;
            chg_v_q    <= chg_v_d;
            chg_q      <= chg_d;
            reject_q   <= reject_d;
        end
    end

    assign led          = led_q;
    assign display      = disp_q;
    assign dispense     = dispense_q;
    assign change_valid = chg_v_q;
    assign change_value = chg_q;
    assign coin_reject  = reject_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed and random stimulus for vending_controller against a
// transaction-level reference model.
module tb_vending_controller;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int TMO = 20;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  btn = '1;
    logic          cancel_n = 1'b1;
    logic          coin_valid = 1'b0;
    logic [CW-1:0] coin_value = '0;
    logic [N-1:0]  led;
    logic [6:0]    display;
    logic          dispense;
    logic          change_valid;
    logic [CW-1:0] change_value;
    logic          coin_reject;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vending_controller #(
        .N_PROD     (N),
        .CREDIT_W   (CW),
        .TIMEOUT    (TMO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .cancel_n    (cancel_n),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .led         (led),
        .display     (display),
        .dispense    (dispense),
        .change_valid(change_valid),
        .change_value(change_value),
        .coin_reject (coin_reject)
    );

    // Reference model: phase 0 = waiting, 1 = product chosen, 2 = paying out
    int           costs [8] = '{3, 5, 7, 4, 6, 2, 9, 8};
    int           m_phase;
    int           m_credit;
    int           m_sel;
    int           m_last;
    int           cyc = 0;
    logic [N:0]   hist [$];
    logic [N-1:0] e_led;
    logic [6:0]   e_disp;
    logic         e_dispense;
    logic         e_cv;
    int           e_chg;
    logic         e_rej;

    function automatic logic [6:0] seg(input int v);
        case (v & 15)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            10:      return 7'h08;
            11:      return 7'h03;
            12:      return 7'h46;
            13:      return 7'h21;
            14:      return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic m_reset();
        m_phase    = 0;
        m_credit   = 0;
        m_sel      = -1;
        m_last     = 0;
        e_dispense = 1'b0;
        e_cv       = 1'b0;
        e_chg      = 0;
        e_rej      = 1'b0;
        hist.delete();
        for (int i = 0; i < SS + 2; i++) hist.push_back({(N + 1){1'b1}});
    endtask

    task automatic pay_dispense();
        e_dispense = 1'b1;
        if (m_credit > costs[m_sel]) begin
            e_cv  = 1'b1;
            e_chg = m_credit - costs[m_sel];
        end
        m_phase = 2;
    endtask

    task automatic pay_refund();
        e_cv    = 1'b1;
        e_chg   = m_credit;
        m_phase = 2;
    endtask

    task automatic m_step(input logic [N:0] pins, input logic cv, input int cval);
        logic [N:0] ev;
        int         idx;
        hist.push_front(pins);
        hist.delete(hist.size() - 1);
        ev         = ~hist[SS] & hist[SS+1];
        e_dispense = 1'b0;
        e_cv       = 1'b0;
        e_chg      = 0;
        e_rej      = 1'b0;
        if (m_phase == 2) begin
            m_credit = cv ? cval : 0;
            m_sel    = -1;
            m_phase  = 0;
        end else begin
            if (cv) begin
                if (m_credit + cval <= 15) m_credit += cval;
                else e_rej = 1'b1;
                m_last = cyc;
            end
            if (m_phase == 0) begin
                idx = -1;
                for (int i = N - 1; i >= 0; i--) if (ev[i]) idx = i;
                if (idx >= 0) begin
                    m_sel = idx;
                    if (m_credit >= costs[idx]) pay_dispense();
                    else begin
                        m_phase = 1;
                        m_last  = cyc;
                    end
                end else if (ev[N] && m_credit > 0) begin
                    pay_refund();
                end
            end else begin
                if (m_credit >= costs[m_sel]) pay_dispense();
                else if (ev[N] || cyc - m_last >= TMO) pay_refund();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_reset();
        else m_step({cancel_n, btn}, coin_valid, int'(coin_value));
        e_led  = (m_sel < 0) ? '1 : ~(N'(1) << m_sel);
        e_disp = (m_phase == 1) ? seg(costs[m_sel] - m_credit) : seg(m_credit);
        cyc++;
        #1;
        chk("led", led, e_led);
        chk("display", display, e_disp);
        chk("dispense", dispense, e_dispense);
        chk("change_valid", change_valid, e_cv);
        chk("change_value", change_value, e_chg);
        chk("coin_reject", coin_reject, e_rej);
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_value = CW'(v);
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    task automatic settle();
        btn      = '1;
        cancel_n = 1'b1;
        wait_n(5);
    endtask

    initial begin
        int np;
        int k;
        m_reset();
        rst = 1'b1;
        wait_n(2);
        chk("rst_led", led, 4'b1111);
        chk("rst_display", display, 7'b1000000);
        chk("rst_change", change_value, 0);
        rst = 1'b0;
        wait_n(3);

        // Product 1, coins 2 then 3, exact payment
        btn[1] = 1'b0;
        wait_n(3);
        chk("t1_led", led, 4'b1101);
        chk("t1_owed5", display, 7'b0010010);
        wait_n(7);
        btn = '1;
        wait_n(2);
        coin(2);
        chk("t1_owed3", display, 7'b0110000);
        coin(3);
        chk("t1_dispense", dispense, 1);
        chk("t1_no_change", change_valid, 0);
        np = int'(dispense);
        step();
        chk("t1_led_clear", led, 4'b1111);
        chk("t1_display0", display, 7'b1000000);
        np += int'(dispense);
        repeat (8) begin
            step();
            np += int'(dispense);
        end
        chk("t1_one_pulse", np, 1);

        // Pre-paid credit 9, product 0 dispenses at once with change 6
        coin(9);
        btn[0] = 1'b0;
        wait_n(3);
        chk("t2_dispense", dispense, 1);
        chk("t2_change_valid", change_valid, 1);
        chk("t2_change_value", change_value, 6);
        settle();

        // Inactivity timeout refunds 20 cycles after the last coin
        btn[2] = 1'b0;
        wait_n(3);
        btn = '1;
        coin(4);
        for (k = 1; k <= 40; k++) begin
            step();
            if (change_valid) break;
        end
        chk("t3_latency", k, 20);
        chk("t3_refund", change_value, 4);
        chk("t3_no_dispense", dispense, 0);
        settle();

        // Simultaneous presses: lowest wins, later presses ignored
        btn[3] = 1'b0;
        btn[1] = 1'b0;
        wait_n(3);
        chk("t4_led", led, 4'b1101);
        btn = '1;
        wait_n(2);
        btn[3] = 1'b0;
        wait_n(4);
        chk("t4_locked", led, 4'b1101);
        btn = '1;
        cancel_n = 1'b0;
        wait_n(3);
        chk("t4_cancel", change_valid, 1);
        settle();

        // Overflowing coin is rejected, credit kept, cancel refunds it
        coin(8);
        chk("t5_display8", display, 7'b0000000);
        coin(8);
        chk("t5_reject", coin_reject, 1);
        chk("t5_credit_kept", display, 7'b0000000);
        step();
        chk("t5_reject_pulse", coin_reject, 0);
        cancel_n = 1'b0;
        wait_n(3);
        chk("t5_refund_valid", change_valid, 1);
        chk("t5_refund_value", change_value, 8);
        settle();

        // Reset mid-transaction discards credit silently
        btn[0] = 1'b0;
        wait_n(3);
        btn = '1;
        coin(1);
        rst = 1'b1;
        step();
        chk("t6_led", led, 4'b1111);
        chk("t6_display", display, 7'b1000000);
        rst = 1'b0;
        np = 0;
        repeat (20) begin
            step();
            np += int'(dispense) + int'(change_valid);
        end
        chk("t6_no_pulses", np, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 29) == 0) btn[i] = ~btn[i];
            end
            if ($urandom_range(0, 39) == 0) cancel_n = ~cancel_n;
            if (((c / 400) % 2) == 0) coin_valid = ($urandom_range(0, 5) == 0);
            else coin_valid = ($urandom_range(0, 49) == 0);
            coin_value = coin_valid ? CW'($urandom_range(0, 9)) : '0;
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        coin_valid = 1'b0;
        coin_value = '0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
- Parametrised vending-machine controller for N_PROD products.
- Synchronises and edge-detects the raw active-low push-buttons and locks one selection.
- Accumulates coin credit, dispenses once credit covers the cost, then returns change. Cancel or inactivity timeout refunds the credit.
- Drives the product LEDs and one 7-segment digit. It sits between the board I/O and the dispenser/coin-return actuators, and replaces the single-register selection path.

Parameters:
- N_PROD, 4, number of products/buttons/LEDs (1..8).
- CREDIT_W, 4, credit/coin/change width; maximum credit is 2^CREDIT_W-1.
- TIMEOUT, 50_000_000, clk cycles of inactivity in SELECTED before auto-refund (minimum 4).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- btn  in  N_PROD  raw product buttons, active-low (0 = pressed), asynchronous.
- cancel_n  in  1  raw cancel button, active-low, asynchronous.
- coin_valid  in  1  one-cycle coin strobe, synchronous to clk.
- coin_value  in  CREDIT_W  coin value, qualified by coin_valid.
- led  out  N_PROD  selected product, active-low one-hot; all 1 when nothing is selected.
- display  out  7  active-low segments {g,f,e,d,c,b,a}: hex amount still owed in SELECTED, hex credit otherwise.
- dispense  out  1  one-cycle pulse; dispenser releases product sel_idx.
- change_valid  out  1  one-cycle pulse qualifying change_value.
- change_value  out  CREDIT_W  coins to return; 0 when change_valid=0.
- coin_reject  out  1  one-cycle pulse: coin not accepted because credit would overflow.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, credit=0, sel_idx=0, timeout counter=0, synchronisers forced to the released level.
  - led all 1, display shows "0", dispense/change_valid/coin_reject=0, change_value=0.
  - Reset asserted mid-transaction discards credit with no refund pulse.
- Inputs:
  - btn and cancel_n pass through SYNC_STAGES flip-flops, then a falling-edge detect.
  - A press acts exactly SYNC_STAGES+1 cycles after the pin falls.
  - Holding a button produces a single event.
  - If several btn edges occur in the same cycle, the lowest index wins.
- Coins:
  - Accepted in every state when credit+coin_value ≤ 2^CREDIT_W-1; the sum is registered next cycle.
  - Otherwise coin_reject pulses the next cycle and credit is unchanged.
  - coin_value=0 with coin_valid=1 is a no-op but still restarts the timeout.
- Cost: COST[sel_idx] from the package table.
- FSM states: IDLE, SELECTED, DISPENSE, REFUND.
- IDLE:
  - Button edge → sel_idx latched, led[sel_idx]=0. If credit (including a same-cycle accepted coin) ≥ cost → DISPENSE, else → SELECTED.
  - Cancel edge with credit>0 → REFUND; with credit=0 it is ignored.
- SELECTED:
  - Further button edges are ignored; the selection is locked.
  - display = cost − credit.
  - Once the updated credit ≥ cost → DISPENSE.
  - Cancel edge, or the counter reaching TIMEOUT−1 → REFUND.
  - The counter clears on entry and on every coin_valid.
- DISPENSE (1 cycle):
  - dispense=1.
  - If credit>cost: change_valid=1 and change_value=credit−cost in the same cycle.
  - Next: credit=0, led all 1, → IDLE.
- REFUND (1 cycle):
  - change_valid=1, change_value=credit.
  - Next: credit=0, led all 1, → IDLE.
- Simultaneous events:
  - Cancel and a coin in the same cycle: the coin is accepted first, and the refund includes it.
  - Cancel edge in the cycle credit reaches cost: dispense wins.
  - Coin during DISPENSE/REFUND: it becomes the new credit after the clear and is not lost.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package vending_pkg holds:
  - state_t enum (IDLE, SELECTED, DISPENSE, REFUND).
  - COST table, 8 entries of 4 bits: 3,5,7,4,6,2,9,8 (only the first N_PROD are used).
  - SEG7 hex-to-segment constant array (active-low; "0"=7'b1000000).
- Sub-module btn_sync_edge, parametrised by width and SYNC_STAGES; instantiated once for {cancel_n, btn}.

Test Plan:
- Select product 1 (btn[1] low for 10 cycles), then coins 2 and 3 → led=4'b1101, display shows 5→3→0. One dispense pulse follows, change_valid stays 0, and led returns to 4'b1111.
- Coin 9 in IDLE, then press btn[0] (cost 3) → DISPENSE directly, with change_valid=1 and change_value=6 in the dispense cycle.
- Select product 2, coin 4, hold with no activity (TIMEOUT=20) → REFUND 20 cycles after the coin, change_value=4, no dispense.
- btn[3] and btn[1] fall in the same cycle → sel_idx=1 and led=4'b1101. A later btn[3] press while in SELECTED is ignored.
- Coins 8 then 8 (CREDIT_W=4) → second coin rejected (coin_reject pulse), credit stays 8. Cancel → change_value=8.
- Select product 0, coin 1, assert rst for 1 cycle → led=4'b1111, display "0", no change_valid or dispense pulse ever asserted.
